// File: rtl/io_access_sequencer.sv
// io_access_sequencer
// Multi-cycle sequencer for the memory-mapped I/O window. Stalls the core while a
// setup/strobe/ready handshake runs against the addressed peripheral, then returns
// read data and raises a sticky error on timeout, unmapped device or illegal request.
module io_access_sequencer #(
   parameter int NUM_DEV = 4,
   parameter int DEV_LSB = 4,
   parameter int DATA_W  = 16,
   parameter int TIMEOUT = 15
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      IORead,
   input  logic                      IOWrite,
   input  logic [9:0]                io_addr,
   input  logic [DATA_W-1:0]         io_wdata,
   output logic                      io_stall,
   output logic [DATA_W-1:0]         io_rdata,
   output logic                      io_err,
   input  logic                      err_clr,
   output logic [NUM_DEV-1:0]        dev_sel,
   output logic [3:0]                dev_addr,
   output logic                      dev_rd,
   output logic                      dev_wr,
   output logic [DATA_W-1:0]         dev_wdata,
   input  logic [NUM_DEV*DATA_W-1:0] dev_rdata,
   input  logic [NUM_DEV-1:0]        dev_ready
);

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE} state_t;

   state_t              r_state, w_state_next;
   logic [NUM_DEV-1:0]  r_sel, w_sel_next;
   logic [3:0]          r_addr, w_addr_next;
   logic [DATA_W-1:0]   r_wdata, w_wdata_next;
   logic [DATA_W-1:0]   r_rdata, w_rdata_next;
   logic                r_is_rd, w_is_rd_next;
   logic                r_rd, w_rd_next;
   logic                r_wr, w_wr_next;
   logic                r_err, w_err_next;
   logic [7:0]          r_cnt, w_cnt_next;

   logic                w_req;
   logic [1:0]          w_dev_idx;
   logic                w_unmapped;
   logic [NUM_DEV-1:0]  w_sel_dec;
   logic                w_ready;
   logic                w_err_set;
   logic [DATA_W-1:0]   w_rdata_mux;

   assign w_req     = IORead | IOWrite;
   assign w_dev_idx = io_addr[DEV_LSB+1:DEV_LSB];
   // Any address bit above the device index field lands outside every peripheral.
   assign w_unmapped = (32'(w_dev_idx) >= NUM_DEV) || (|(io_addr >> (DEV_LSB + 2)));
   assign w_sel_dec  = NUM_DEV'(1) << w_dev_idx;
   // dev_sel is one-hot and held through ACCESS, so masking picks the selected ready only.
   assign w_ready    = |(dev_ready & r_sel);

   // Read-data mux driven by the latched one-hot select
   always_comb begin
      w_rdata_mux = '0;
      for (int i = 0; i < NUM_DEV; i++) begin
         if (r_sel[i]) w_rdata_mux |= dev_rdata[i*DATA_W +: DATA_W];
      end
   end

   // Next-state and next-register values for the handshake FSM
   always_comb begin
      w_state_next = r_state;
      w_sel_next   = r_sel;
      w_addr_next  = r_addr;
      w_wdata_next = r_wdata;
      w_rdata_next = r_rdata;
      w_is_rd_next = r_is_rd;
      w_rd_next    = r_rd;
      w_wr_next    = r_wr;
      w_cnt_next   = r_cnt;
      w_err_set    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_req) begin
               w_addr_next  = io_addr[3:0];
               w_wdata_next = io_wdata;
               // Both strobes together: perform the read, flag the request as illegal.
               w_is_rd_next = IORead;
               if (IORead && IOWrite) w_err_set = 1'b1;
               if (w_unmapped) begin
                  w_rdata_next = '0;
                  w_err_set    = 1'b1;
                  w_state_next = S_DONE;
               end else begin
                  w_sel_next   = w_sel_dec;
                  w_state_next = S_SETUP;
               end
            end
         end
         S_SETUP: begin
            w_cnt_next   = 8'd0;
            w_rd_next    = r_is_rd;
            w_wr_next    = ~r_is_rd;
            w_state_next = S_ACCESS;
         end
         S_ACCESS: begin
            if (w_ready) begin
               if (r_is_rd) w_rdata_next = w_rdata_mux;
               w_rd_next    = 1'b0;
               w_wr_next    = 1'b0;
               w_sel_next   = '0;
               w_state_next = S_DONE;
            end else if (r_cnt == 8'(TIMEOUT - 1)) begin
               if (r_is_rd) w_rdata_next = '0;
               w_err_set    = 1'b1;
               w_rd_next    = 1'b0;
               w_wr_next    = 1'b0;
               w_sel_next   = '0;
               w_state_next = S_DONE;
            end else begin
               w_cnt_next = r_cnt + 8'd1;
            end
         end
         S_DONE: begin
            // The request still visible here belongs to the instruction now committing.
            w_sel_next   = '0;
            w_rd_next    = 1'b0;
            w_wr_next    = 1'b0;
            w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
      // A new error in the same cycle as err_clr takes priority.
      w_err_next = w_err_set | (r_err & ~err_clr);
   end

   // State and output registers; reset aborts any access and drops strobes at once
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_sel   <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_is_rd <= 1'b0;
         r_rd    <= 1'b0;
         r_wr    <= 1'b0;
         r_err   <= 1'b0;
         r_cnt   <= 8'd0;
      end else begin
         r_state <= w_state_next;
         r_sel   <= w_sel_next;
         r_addr  <= w_addr_next;
         r_wdata <= w_wdata_next;
         r_rdata <= w_rdata_next;
         r_is_rd <= w_is_rd_next;
         r_rd    <= w_rd_next;
         r_wr    <= w_wr_next;
         r_err   <= w_err_next;
         r_cnt   <= w_cnt_next;
      end
   end

   // Stall is combinational in IDLE so the core holds the PC in the request cycle itself.
   assign io_stall  = ((r_state == S_IDLE) && w_req) || (r_state == S_SETUP) || (r_state == S_ACCESS);
   assign io_rdata  = r_rdata;
   assign io_err    = r_err;
   assign dev_sel   = r_sel;
   assign dev_addr  = r_addr;
   assign dev_rd    = r_rd;
   assign dev_wr    = r_wr;
   assign dev_wdata = r_wdata;

endmodule

// File: tb/tb_io_access_sequencer.sv
// tb_io_access_sequencer
// Scoreboard bench: each scenario pushes its expected outcome, drives the request,
// measures stall/strobe behaviour until DONE, then pops and compares.
module tb_io_access_sequencer;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        IORead = 1'b0, IOWrite = 1'b0, err_clr = 1'b0;
   logic [9:0]  io_addr = '0;
   logic [15:0] io_wdata = '0;
   logic        io_stall, io_err, dev_rd, dev_wr;
   logic [15:0] io_rdata, dev_wdata;
   logic [3:0]  dev_sel, dev_addr;
   logic [63:0] dev_rdata = '0;
   logic [3:0]  dev_ready = '0;

   // second instance with only two peripherals, for the unmapped-device case
   logic        b_IORead = 1'b0, b_IOWrite = 1'b0, b_err_clr = 1'b0;
   logic [9:0]  b_io_addr = '0;
   logic [15:0] b_io_wdata = '0;
   logic        b_io_stall, b_io_err, b_dev_rd, b_dev_wr;
   logic [15:0] b_io_rdata, b_dev_wdata;
   logic [1:0]  b_dev_sel;
   logic [3:0]  b_dev_addr;
   logic [31:0] b_dev_rdata = 32'h7777_6666;
   logic [1:0]  b_dev_ready = 2'b11;

   int n_checks = 0;
   int n_pass   = 0;
   int rd_starts = 0;
   logic prev_rd = 1'b0;

   typedef struct { int stall; int rd_n; int wr_n; logic [15:0] rdata; logic err; } exp_t;
   typedef struct { int stall; int rd_n; int wr_n; logic [3:0] sel; logic [3:0] addr;
                    logic [15:0] wdata; logic [15:0] rdata; logic err; bit done; } res_t;
   exp_t sb[$];

   always #5 clock = ~clock;

   io_access_sequencer #(.NUM_DEV(4), .DEV_LSB(4), .DATA_W(16), .TIMEOUT(15)) u_dut (
      .clock(clock), .reset(reset), .IORead(IORead), .IOWrite(IOWrite),
      .io_addr(io_addr), .io_wdata(io_wdata), .io_stall(io_stall), .io_rdata(io_rdata),
      .io_err(io_err), .err_clr(err_clr), .dev_sel(dev_sel), .dev_addr(dev_addr),
      .dev_rd(dev_rd), .dev_wr(dev_wr), .dev_wdata(dev_wdata),
      .dev_rdata(dev_rdata), .dev_ready(dev_ready));

   io_access_sequencer #(.NUM_DEV(2), .DEV_LSB(4), .DATA_W(16), .TIMEOUT(15)) u_dut2 (
      .clock(clock), .reset(reset), .IORead(b_IORead), .IOWrite(b_IOWrite),
      .io_addr(b_io_addr), .io_wdata(b_io_wdata), .io_stall(b_io_stall), .io_rdata(b_io_rdata),
      .io_err(b_io_err), .err_clr(b_err_clr), .dev_sel(b_dev_sel), .dev_addr(b_dev_addr),
      .dev_rd(b_dev_rd), .dev_wr(b_dev_wr), .dev_wdata(b_dev_wdata),
      .dev_rdata(b_dev_rdata), .dev_ready(b_dev_ready));

   // count read-strobe starts, sampled away from the active edge
   always @(negedge clock) begin
      if (dev_rd && !prev_rd) rd_starts = rd_starts + 1;
      prev_rd = dev_rd;
   end

   // Drive one request at a negedge and follow it until DONE (stall low), measuring it.
   // rdy_after: ACCESS cycle (1-based) in which the selected device raises ready; 0 = never.
   task automatic do_req(input logic rd, input logic wr, input logic [9:0] addr,
                         input logic [15:0] wd, input int rdy_after, input logic [3:0] noise,
                         input bit keep, output res_t r);
      int k;
      k = 0;
      r.stall = 0; r.rd_n = 0; r.wr_n = 0; r.sel = '0; r.addr = '0; r.wdata = '0;
      r.rdata = '0; r.err = 1'b0; r.done = 1'b0;
      IORead = rd; IOWrite = wr; io_addr = addr; io_wdata = wd; dev_ready = noise;
      for (int cyc = 0; cyc < 300; cyc++) begin
         #1;
         if (!io_stall) begin
            r.rdata = io_rdata; r.err = io_err; r.done = 1'b1;
            break;
         end
         r.stall++;
         if (dev_rd) r.rd_n++;
         if (dev_wr) r.wr_n++;
         if (dev_rd || dev_wr) begin
            k++;
            r.sel = dev_sel; r.addr = dev_addr; r.wdata = dev_wdata;
         end
         dev_ready = (k != 0 && k == rdy_after) ? (dev_sel | noise) : noise;
         @(negedge clock);
      end
      if (!keep) begin IORead = 1'b0; IOWrite = 1'b0; end
      dev_ready = '0;
      $display("xact addr=%03h rd=%0b wr=%0b stall=%0d rd_cyc=%0d wr_cyc=%0d sel=%b rdata=%04h err=%0b done=%0b",
               addr, rd, wr, r.stall, r.rd_n, r.wr_n, r.sel, r.rdata, r.err, r.done);
      @(negedge clock);
   endtask

   task automatic test_reset();
      #1;
      n_checks++; if (io_stall !== 1'b0)   $display("FAIL reset_stall: got %b expected 0", io_stall); else n_pass++;
      n_checks++; if (io_rdata !== 16'h0)  $display("FAIL reset_rdata: got %h expected 0000", io_rdata); else n_pass++;
      n_checks++; if (io_err !== 1'b0)     $display("FAIL reset_err: got %b expected 0", io_err); else n_pass++;
      n_checks++; if (dev_sel !== 4'h0)    $display("FAIL reset_sel: got %b expected 0000", dev_sel); else n_pass++;
      n_checks++; if (dev_addr !== 4'h0)   $display("FAIL reset_addr: got %h expected 0", dev_addr); else n_pass++;
      n_checks++; if ({dev_rd, dev_wr} !== 2'b00) $display("FAIL reset_strobes: got %b expected 00", {dev_rd, dev_wr}); else n_pass++;
      n_checks++; if (dev_wdata !== 16'h0) $display("FAIL reset_wdata: got %h expected 0000", dev_wdata); else n_pass++;
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
   endtask

   task automatic test_read();
      res_t r; exp_t e;
      dev_rdata[16 +: 16] = 16'hBEEF;
      sb.push_back('{3, 1, 0, 16'hBEEF, 1'b0});
      do_req(1'b1, 1'b0, 10'h010, 16'h0, 1, 4'b0000, 1'b0, r);
      e = sb.pop_front();
      n_checks++; if (!r.done)             $display("FAIL read_done: got no DONE expected DONE"); else n_pass++;
      n_checks++; if (r.stall !== e.stall) $display("FAIL read_stall: got %0d expected %0d", r.stall, e.stall); else n_pass++;
      n_checks++; if (r.rd_n !== e.rd_n)   $display("FAIL read_rd_cycles: got %0d expected %0d", r.rd_n, e.rd_n); else n_pass++;
      n_checks++; if (r.wr_n !== e.wr_n)   $display("FAIL read_wr_cycles: got %0d expected %0d", r.wr_n, e.wr_n); else n_pass++;
      n_checks++; if (r.sel !== 4'b0010)   $display("FAIL read_sel: got %b expected 0010", r.sel); else n_pass++;
      n_checks++; if (r.rdata !== e.rdata) $display("FAIL read_rdata: got %h expected %h", r.rdata, e.rdata); else n_pass++;
      n_checks++; if (r.err !== e.err)     $display("FAIL read_err: got %b expected %b", r.err, e.err); else n_pass++;
   endtask

   task automatic test_write();
      res_t r; exp_t e;
      dev_rdata[32 +: 16] = 16'h5555;
      // a write leaves io_rdata holding the previous read value
      sb.push_back('{5, 0, 3, 16'hBEEF, 1'b0});
      do_req(1'b0, 1'b1, 10'h023, 16'h1234, 3, 4'b0000, 1'b0, r);
      e = sb.pop_front();
      n_checks++; if (r.stall !== e.stall) $display("FAIL write_stall: got %0d expected %0d", r.stall, e.stall); else n_pass++;
      n_checks++; if (r.wr_n !== e.wr_n)   $display("FAIL write_wr_cycles: got %0d expected %0d", r.wr_n, e.wr_n); else n_pass++;
      n_checks++; if (r.rd_n !== e.rd_n)   $display("FAIL write_rd_cycles: got %0d expected %0d", r.rd_n, e.rd_n); else n_pass++;
      n_checks++; if (r.sel !== 4'b0100)   $display("FAIL write_sel: got %b expected 0100", r.sel); else n_pass++;
      n_checks++; if (r.addr !== 4'h3)     $display("FAIL write_addr: got %h expected 3", r.addr); else n_pass++;
      n_checks++; if (r.wdata !== 16'h1234) $display("FAIL write_wdata: got %h expected 1234", r.wdata); else n_pass++;
      n_checks++; if (r.rdata !== e.rdata) $display("FAIL write_rdata_kept: got %h expected %h", r.rdata, e.rdata); else n_pass++;
      n_checks++; if (r.err !== e.err)     $display("FAIL write_err: got %b expected %b", r.err, e.err); else n_pass++;
   endtask

   task automatic test_timeout();
      res_t r; exp_t e;
      dev_rdata[0 +: 16] = 16'h9999;
      // other devices report ready the whole time; only dev0 counts
      sb.push_back('{17, 15, 0, 16'h0000, 1'b1});
      do_req(1'b1, 1'b0, 10'h000, 16'h0, 0, 4'b1110, 1'b0, r);
      e = sb.pop_front();
      n_checks++; if (r.stall !== e.stall) $display("FAIL timeout_stall: got %0d expected %0d", r.stall, e.stall); else n_pass++;
      n_checks++; if (r.rd_n !== e.rd_n)   $display("FAIL timeout_rd_cycles: got %0d expected %0d", r.rd_n, e.rd_n); else n_pass++;
      n_checks++; if (r.sel !== 4'b0001)   $display("FAIL timeout_sel: got %b expected 0001", r.sel); else n_pass++;
      n_checks++; if (r.rdata !== e.rdata) $display("FAIL timeout_rdata: got %h expected %h", r.rdata, e.rdata); else n_pass++;
      n_checks++; if (r.err !== e.err)     $display("FAIL timeout_err: got %b expected %b", r.err, e.err); else n_pass++;
      #1;
      n_checks++; if (io_err !== 1'b1)     $display("FAIL timeout_err_sticky: got %b expected 1", io_err); else n_pass++;
      @(negedge clock); err_clr = 1'b1;
      @(negedge clock); err_clr = 1'b0;
      #1;
      n_checks++; if (io_err !== 1'b0)     $display("FAIL timeout_err_clr: got %b expected 0", io_err); else n_pass++;
      @(negedge clock);
   endtask

   task automatic test_illegal();
      res_t r; exp_t e;
      dev_rdata[16 +: 16] = 16'hA5A5;
      sb.push_back('{3, 1, 0, 16'hA5A5, 1'b1});
      do_req(1'b1, 1'b1, 10'h015, 16'hFFFF, 1, 4'b0000, 1'b0, r);
      e = sb.pop_front();
      n_checks++; if (r.stall !== e.stall) $display("FAIL illegal_stall: got %0d expected %0d", r.stall, e.stall); else n_pass++;
      n_checks++; if (r.rd_n !== e.rd_n)   $display("FAIL illegal_rd_cycles: got %0d expected %0d", r.rd_n, e.rd_n); else n_pass++;
      n_checks++; if (r.wr_n !== e.wr_n)   $display("FAIL illegal_wr_cycles: got %0d expected %0d", r.wr_n, e.wr_n); else n_pass++;
      n_checks++; if (r.addr !== 4'h5)     $display("FAIL illegal_addr: got %h expected 5", r.addr); else n_pass++;
      n_checks++; if (r.rdata !== e.rdata) $display("FAIL illegal_rdata: got %h expected %h", r.rdata, e.rdata); else n_pass++;
      n_checks++; if (r.err !== e.err)     $display("FAIL illegal_err: got %b expected %b", r.err, e.err); else n_pass++;
      err_clr = 1'b1;
      @(negedge clock); err_clr = 1'b0;
      #1;
      n_checks++; if (io_err !== 1'b0)     $display("FAIL illegal_err_clr: got %b expected 0", io_err); else n_pass++;
      @(negedge clock);
   endtask

   task automatic test_back_to_back();
      res_t r1, r2; exp_t e;
      int base;
      base = rd_starts;
      dev_rdata[16 +: 16] = 16'h1111;
      sb.push_back('{3, 1, 0, 16'h1111, 1'b0});
      sb.push_back('{4, 2, 0, 16'h2222, 1'b0});
      // IORead stays high through DONE into the next instruction
      do_req(1'b1, 1'b0, 10'h010, 16'h0, 1, 4'b0000, 1'b1, r1);
      dev_rdata[16 +: 16] = 16'h2222;
      do_req(1'b1, 1'b0, 10'h010, 16'h0, 2, 4'b0000, 1'b0, r2);
      e = sb.pop_front();
      n_checks++; if (r1.stall !== e.stall) $display("FAIL b2b_first_stall: got %0d expected %0d", r1.stall, e.stall); else n_pass++;
      n_checks++; if (r1.rdata !== e.rdata) $display("FAIL b2b_first_rdata: got %h expected %h", r1.rdata, e.rdata); else n_pass++;
      e = sb.pop_front();
      n_checks++; if (r2.stall !== e.stall) $display("FAIL b2b_second_stall: got %0d expected %0d", r2.stall, e.stall); else n_pass++;
      n_checks++; if (r2.rd_n !== e.rd_n)   $display("FAIL b2b_second_rd_cycles: got %0d expected %0d", r2.rd_n, e.rd_n); else n_pass++;
      n_checks++; if (r2.rdata !== e.rdata) $display("FAIL b2b_second_rdata: got %h expected %h", r2.rdata, e.rdata); else n_pass++;
      n_checks++; if (r2.err !== e.err)     $display("FAIL b2b_second_err: got %b expected %b", r2.err, e.err); else n_pass++;
      #1;
      n_checks++; if (io_stall !== 1'b0)    $display("FAIL b2b_idle_after: got stall %b expected 0", io_stall); else n_pass++;
      n_checks++; if (rd_starts - base !== 2) $display("FAIL b2b_transactions: got %0d expected 2", rd_starts - base); else n_pass++;
      @(negedge clock);
   endtask

   task automatic test_reset_abort();
      bit found;
      found = 1'b0;
      IORead = 1'b1; io_addr = 10'h000; dev_ready = '0;
      for (int cyc = 0; cyc < 8; cyc++) begin
         #1;
         if (dev_rd) begin found = 1'b1; break; end
         @(negedge clock);
      end
      n_checks++; if (!found) $display("FAIL abort_reach_access: got no dev_rd expected dev_rd"); else n_pass++;
      reset = 1'b0;
      #1;
      n_checks++; if ({dev_rd, dev_wr} !== 2'b00) $display("FAIL abort_strobes: got %b expected 00", {dev_rd, dev_wr}); else n_pass++;
      n_checks++; if (dev_sel !== 4'h0)  $display("FAIL abort_sel: got %b expected 0000", dev_sel); else n_pass++;
      IORead = 1'b0;
      #1;
      n_checks++; if (io_stall !== 1'b0) $display("FAIL abort_idle: got stall %b expected 0", io_stall); else n_pass++;
      $display("xact reset abort during ACCESS");
      @(negedge clock); reset = 1'b1;
      @(negedge clock);
   endtask

   task automatic test_unmapped();
      exp_t e;
      int stall_n, strobe_n;
      logic [15:0] got_rdata;
      logic got_err;
      logic [1:0] got_sel;
      bit done;
      // valid read of dev1 first so the zeroed io_rdata of the unmapped access is visible
      sb.push_back('{3, 1, 0, 16'h7777, 1'b0});
      sb.push_back('{1, 0, 0, 16'h0000, 1'b1});
      for (int k = 0; k < 2; k++) begin
         stall_n = 0; strobe_n = 0; done = 1'b0; got_rdata = '0; got_err = 1'b0; got_sel = '0;
         b_IORead  = 1'b1;
         b_io_addr = (k == 0) ? 10'h010 : 10'h030;
         // err_clr alongside the new error: the error must win
         b_err_clr = (k == 1);
         for (int cyc = 0; cyc < 20; cyc++) begin
            #1;
            if (!b_io_stall) begin
               done = 1'b1; got_rdata = b_io_rdata; got_err = b_io_err; got_sel = b_dev_sel;
               break;
            end
            stall_n++;
            if (b_dev_rd || b_dev_wr) strobe_n++;
            @(negedge clock);
            b_err_clr = 1'b0;
         end
         b_IORead = 1'b0; b_err_clr = 1'b0;
         $display("xact dut2 addr=%03h stall=%0d strobes=%0d rdata=%04h err=%0b done=%0b",
                  b_io_addr, stall_n, strobe_n, got_rdata, got_err, done);
         e = sb.pop_front();
         n_checks++; if (stall_n !== e.stall)  $display("FAIL unmapped%0d_stall: got %0d expected %0d", k, stall_n, e.stall); else n_pass++;
         n_checks++; if (strobe_n !== e.rd_n)  $display("FAIL unmapped%0d_strobes: got %0d expected %0d", k, strobe_n, e.rd_n); else n_pass++;
         n_checks++; if (got_rdata !== e.rdata) $display("FAIL unmapped%0d_rdata: got %h expected %h", k, got_rdata, e.rdata); else n_pass++;
         n_checks++; if (got_err !== e.err)    $display("FAIL unmapped%0d_err: got %b expected %b", k, got_err, e.err); else n_pass++;
         n_checks++; if (got_sel !== 2'b00)    $display("FAIL unmapped%0d_done_sel: got %b expected 00", k, got_sel); else n_pass++;
         @(negedge clock);
      end
      b_err_clr = 1'b1;
      @(negedge clock); b_err_clr = 1'b0;
      #1;
      n_checks++; if (b_io_err !== 1'b0) $display("FAIL unmapped_err_clr: got %b expected 0", b_io_err); else n_pass++;
      @(negedge clock);
   endtask

   initial begin
      test_reset();
      test_read();
      test_write();
      test_timeout();
      test_illegal();
      test_back_to_back();
      test_reset_abort();
      test_unmapped();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
